// File: rtl/alu32_pkg.sv
// Shared types and sizing helpers for the ALU result LED pager.
package alu32_pkg;

    typedef enum logic {
        ST_LIVE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam int LED_W_DEFAULT = 8;

    function automatic int page_count(input int data_w, input int led_w);
        return data_w / led_w;
    endfunction

    // Never narrower than one bit, even for a single-page configuration.
    function automatic int page_idx_w(input int data_w, input int led_w);
        return (data_w / led_w > 1) ? $clog2(data_w / led_w) : 1;
    endfunction

endpackage

// File: rtl/alu32_led_pager_debounce.sv
// Push-button conditioning: two-flop synchroniser, level debounce and a
// registered one-cycle pulse on each accepted press (stable 1->0).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn_n;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            // Any agreement between synced and stable level restarts the hold window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu32_led_pager.sv
// Shows a DATA_W-bit ALU result on LED_W LEDs, one page per button press.
// Optional auto-scroll of the frozen snapshot: ALU32_LED_PAGER_AUTO_SCROLL_EN.
module alu32_led_pager
    import alu32_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int LED_W           = LED_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCROLL_CYCLES   = 50000000
) (
    input  logic                                  CLK,
    input  logic                                  rst,
    input  logic                                  pushButton,
    input  logic [DATA_W-1:0]                     in,
    output logic [LED_W-1:0]                      leds,
    output logic [page_idx_w(DATA_W, LED_W)-1:0]  pageIdx,
    output logic                                  frozen
);

    localparam int PAGES = page_count(DATA_W, LED_W);
    localparam int PW    = page_idx_w(DATA_W, LED_W);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

    if ((DATA_W % LED_W) != 0 || SCROLL_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("alu32_led_pager: illegal parameter combination");
    end

    state_t            state;
    logic [DATA_W-1:0] snapshot;
    logic              press;
    logic [PW-1:0]     page_inc;

    assign page_inc = (pageIdx == PAGE_LAST) ? '0 : pageIdx + 1'b1;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK   (CLK),
        .rst   (rst),
        .btn_n (pushButton),
        .press (press)
    );

`ifdef ALU32_LED_PAGER_AUTO_SCROLL_EN
    localparam int SCW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_CYCLES - 1);

    logic [SCW-1:0] scroll_cnt;
`endif

    // Outputs are computed from the next page so they change together with state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= ST_LIVE;
            snapshot <= '0;
            leds     <= '0;
            pageIdx  <= '0;
            frozen   <= 1'b0;
`ifdef ALU32_LED_PAGER_AUTO_SCROLL_EN
            scroll_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_LIVE: begin
                    leds    <= in[LED_W-1:0];
                    pageIdx <= '0;
                    frozen  <= 1'b0;
                    if (press) begin
                        snapshot <= in;
                        state    <= ST_SHOW;
                        frozen   <= 1'b1;
`ifdef ALU32_LED_PAGER_AUTO_SCROLL_EN
                        scroll_cnt <= '0;
`endif
                    end
                end
                ST_SHOW: begin
`ifdef ALU32_LED_PAGER_AUTO_SCROLL_EN
                    if (press) begin
                        state   <= ST_LIVE;
                        pageIdx <= '0;
                        frozen  <= 1'b0;
                        leds    <= in[LED_W-1:0];
                    end else if (scroll_cnt == SCROLL_LAST) begin
                        scroll_cnt <= '0;
                        pageIdx    <= page_inc;
                        leds       <= snapshot[page_inc*LED_W +: LED_W];
                    end else begin
                        scroll_cnt <= scroll_cnt + 1'b1;
                        leds       <= snapshot[pageIdx*LED_W +: LED_W];
                    end
`else
                    if (press && pageIdx == PAGE_LAST) begin
                        state   <= ST_LIVE;
                        pageIdx <= '0;
                        frozen  <= 1'b0;
                        leds    <= in[LED_W-1:0];
                    end else if (press) begin
                        pageIdx <= page_inc;
                        leds    <= snapshot[page_inc*LED_W +: LED_W];
                    end else begin
                        leds <= snapshot[pageIdx*LED_W +: LED_W];
                    end
`endif
                end
                default: state <= ST_LIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_led_pager.sv
// Directed scoreboard bench for alu32_led_pager (DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8).
module tb_alu32_led_pager;

    localparam int DB = 4;
    localparam int SC = 8;

    typedef struct packed {
        logic [7:0] leds;
        logic [1:0] page;
        logic       frozen;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst;
    logic        pushButton;
    logic [31:0] in;
    logic [7:0]  leds;
    logic [1:0]  pageIdx;
    logic        frozen;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alu32_led_pager #(
        .DATA_W         (32),
        .LED_W          (8),
        .DEBOUNCE_CYCLES(DB),
        .SCROLL_CYCLES  (SC)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .pushButton(pushButton),
        .in        (in),
        .leds      (leds),
        .pageIdx   (pageIdx),
        .frozen    (frozen)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (leds === e.leds) else begin
            n_fail++;
            $error("FAIL %s leds: got %h expected %h", tag, leds, e.leds);
        end
        n_assert++;
        assert (pageIdx === e.page) else begin
            n_fail++;
            $error("FAIL %s pageIdx: got %0d expected %0d", tag, pageIdx, e.page);
        end
        n_assert++;
        assert (frozen === e.frozen) else begin
            n_fail++;
            $error("FAIL %s frozen: got %b expected %b", tag, frozen, e.frozen);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] l, input logic [1:0] p,
                              input logic f);
        sb.push_back('{leds: l, page: p, frozen: f});
        check(tag);
    endtask

    // Clean press: accepted by the FSM 8 edges after the fall, then released.
    task automatic press_btn();
        pushButton = 1'b0;
        tick(10);
        pushButton = 1'b1;
        tick(10);
    endtask

    initial begin
        rst        = 1'b1;
        pushButton = 1'b1;
        in         = 32'hA1B2C3D4;
        tick(3);
        expect_out("reset", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        tick(1);
        expect_out("live_after_reset", 8'hD4, 2'd0, 1'b0);

`ifndef ALU32_LED_PAGER_AUTO_SCROLL_EN
        // Press latency: FSM reacts on edge DB+4 after the fall.
        pushButton = 1'b0;
        tick(DB + 3);
        expect_out("press_latency_before", 8'hD4, 2'd0, 1'b0);
        tick(1);
        expect_out("press_enter_show", 8'hD4, 2'd0, 1'b1);
        in         = 32'h00000000;
        pushButton = 1'b1;
        tick(10);
        expect_out("show_ignores_in", 8'hD4, 2'd0, 1'b1);
        press_btn();
        expect_out("page1", 8'hC3, 2'd1, 1'b1);
        press_btn();
        expect_out("page2", 8'hB2, 2'd2, 1'b1);
        press_btn();
        expect_out("page3", 8'hA1, 2'd3, 1'b1);
        press_btn();
        expect_out("wrap_to_live", 8'h00, 2'd0, 1'b0);

        // Bounce shorter than the debounce window.
        in = 32'h12345678;
        tick(2);
        expect_out("live_track", 8'h78, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            pushButton = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        pushButton = 1'b1;
        tick(10);
        expect_out("bounce_no_press", 8'h78, 2'd0, 1'b0);
        in = 32'h9ABCDEF0;
        tick(1);
        expect_out("bounce_live_track", 8'hF0, 2'd0, 1'b0);

        // Long hold gives exactly one press; release gives none.
        pushButton = 1'b0;
        tick(100);
        expect_out("hold_one_press", 8'hF0, 2'd0, 1'b1);
        pushButton = 1'b1;
        tick(10);
        expect_out("release_no_press", 8'hF0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) press_btn();
        expect_out("back_to_live", 8'hF0, 2'd0, 1'b0);

        // Reset in the middle of a debounce count, button held throughout.
        in         = 32'h11223344;
        pushButton = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        expect_out("rst_mid_debounce", 8'h00, 2'd0, 1'b0);
        tick(5);
        expect_out("rst_held_no_press", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        tick(1);
        expect_out("post_rst_live", 8'h44, 2'd0, 1'b0);
        tick(DB + 2);
        expect_out("post_rst_before_press", 8'h44, 2'd0, 1'b0);
        tick(1);
        expect_out("post_rst_press", 8'h44, 2'd0, 1'b1);
        pushButton = 1'b1;
        tick(10);
        expect_out("post_rst_single_press", 8'h44, 2'd0, 1'b1);
        press_btn();
        press_btn();
        expect_out("show_page2", 8'h22, 2'd2, 1'b1);

        // Reset in the very cycle a press reaches the FSM.
        pushButton = 1'b0;
        tick(DB + 3);
        rst = 1'b1;
        tick(1);
        expect_out("rst_with_press", 8'h00, 2'd0, 1'b0);
        rst        = 1'b0;
        pushButton = 1'b1;
        tick(1);
        expect_out("rst_press_live", 8'h44, 2'd0, 1'b0);
        tick(12);
        expect_out("rst_press_discarded", 8'h44, 2'd0, 1'b0);
`else
        pushButton = 1'b0;
        tick(DB + 4);
        expect_out("scroll_enter", 8'hD4, 2'd0, 1'b1);
        in         = 32'h00000000;
        pushButton = 1'b1;
        tick(SC - 1);
        expect_out("scroll_hold0", 8'hD4, 2'd0, 1'b1);
        tick(1);
        expect_out("scroll_p1", 8'hC3, 2'd1, 1'b1);
        tick(SC);
        expect_out("scroll_p2", 8'hB2, 2'd2, 1'b1);
        tick(SC);
        expect_out("scroll_p3", 8'hA1, 2'd3, 1'b1);
        tick(SC);
        expect_out("scroll_wrap", 8'hD4, 2'd0, 1'b1);

        // The press lands on the same edge as the next scroll tick.
        pushButton = 1'b0;
        tick(DB + 3);
        expect_out("scroll_before_coincide", 8'hD4, 2'd0, 1'b1);
        tick(1);
        expect_out("press_beats_scroll", 8'h00, 2'd0, 1'b0);
        pushButton = 1'b1;
        tick(10);
        expect_out("scroll_live", 8'h00, 2'd0, 1'b0);

        in = 32'h55667788;
        press_btn();
        expect_out("scroll_second_entry", 8'h77, 2'd1, 1'b1);
        press_btn();
        expect_out("scroll_press_exit", 8'h88, 2'd0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
